// File: rtl/timer_pkg.sv
// Shared types and sizing for the timer clock/reset controller.
package timer_pkg;

    localparam int unsigned DEF_DIV_W = 3;
    localparam int unsigned DEF_PRE_W = (1 << DEF_DIV_W) - 1;

    typedef enum logic [1:0] {
        ST_HOLD   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RUN    = 2'd2
    } state_t;

    // The prescale counter must reach 2^(2^div_w-1)-1.
    function automatic int unsigned pre_width(input int unsigned div_w);
        return (1 << div_w) - 1;
    endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Prescale counter with glitch-free divider reconfiguration.
// The new divider is taken only on a tick, so no short or long ticks occur.
module timer_prescaler
    import timer_pkg::*;
#(
    parameter int unsigned DIV_W = DEF_DIV_W
) (
    input  logic             pclk,
    input  logic             preset,
    input  logic             run,
    input  logic             clear,
    input  logic             div_en,
    input  logic [DIV_W-1:0] div_val,
    output logic             cnt_en,
    output logic             cfg_pending
);

    localparam int unsigned PRE_W = pre_width(DIV_W);

    logic [PRE_W-1:0] pre_cnt;
    logic [PRE_W-1:0] limit;
    logic [PRE_W:0]   one_hot;
    logic             act_en;
    logic [DIV_W-1:0] act_val;
    logic             hit;

    assign one_hot     = (PRE_W+1)'(1) << act_val;
    assign limit       = act_en ? PRE_W'(one_hot - (PRE_W+1)'(1)) : '0;
    assign hit         = (pre_cnt == limit);
    assign cnt_en      = run & hit & ~preset & ~clear;
    assign cfg_pending = run & ({div_en, div_val} != {act_en, act_val});

    always_ff @(posedge pclk) begin
        if (preset) begin
            pre_cnt <= '0;
            act_en  <= 1'b0;
            act_val <= '0;
        end else if (!run) begin
            pre_cnt <= '0;
            act_en  <= div_en;
            act_val <= div_val;
        end else if (clear) begin
            pre_cnt <= '0;
        end else if (hit) begin
            pre_cnt <= '0;
            act_en  <= div_en;
            act_val <= div_val;
        end else begin
            pre_cnt <= pre_cnt + PRE_W'(1);
        end
    end

endmodule

// File: rtl/timer_clk_rst_ctrl.sv
// Reset sequencer for the timer core: stretches resets, settles one cycle,
// then enables the prescaled count tick.
module timer_clk_rst_ctrl
    import timer_pkg::*;
#(
    parameter int unsigned RST_HOLD_CYC = 4,
    parameter int unsigned DIV_W        = DEF_DIV_W
) (
    input  logic             pclk,
    input  logic             preset,
    input  logic             sw_rst_req,
    input  logic             div_en,
    input  logic [DIV_W-1:0] div_val,
    output logic             timer_rst,
    output logic             rst_done,
    output logic             cnt_en,
    output logic             cfg_pending
);

    localparam int unsigned HOLD_W = $clog2(RST_HOLD_CYC + 1);

    state_t            state;
    logic [HOLD_W-1:0] hold_cnt;

    always_ff @(posedge pclk) begin
        if (preset) begin
            state     <= ST_HOLD;
            hold_cnt  <= '0;
            timer_rst <= 1'b1;
            rst_done  <= 1'b0;
        end else begin
            rst_done <= 1'b0;
            case (state)
                ST_HOLD: begin
                    timer_rst <= 1'b1;
                    if (sw_rst_req) begin
                        hold_cnt <= '0;
                    end else if (hold_cnt == HOLD_W'(RST_HOLD_CYC - 1)) begin
                        hold_cnt  <= '0;
                        state     <= ST_SETTLE;
                        timer_rst <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                ST_SETTLE: begin
                    if (sw_rst_req) begin
                        state     <= ST_HOLD;
                        hold_cnt  <= '0;
                        timer_rst <= 1'b1;
                    end else begin
                        state    <= ST_RUN;
                        rst_done <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (sw_rst_req) begin
                        state     <= ST_HOLD;
                        hold_cnt  <= '0;
                        timer_rst <= 1'b1;
                    end
                end
                default: begin
                    state     <= ST_HOLD;
                    hold_cnt  <= '0;
                    timer_rst <= 1'b1;
                end
            endcase
        end
    end

    timer_prescaler #(
        .DIV_W(DIV_W)
    ) u_prescaler (
        .pclk       (pclk),
        .preset     (preset),
        .run        (state == ST_RUN),
        .clear      (sw_rst_req),
        .div_en     (div_en),
        .div_val    (div_val),
        .cnt_en     (cnt_en),
        .cfg_pending(cfg_pending)
    );

endmodule

// File: tb/tb_timer_clk_rst_ctrl.sv
// Bench for timer_clk_rst_ctrl: directed scenarios plus a randomized run
// against a cycle-count reference model.
module tb_timer_clk_rst_ctrl;

    localparam int unsigned HOLD = 4;
    localparam int unsigned DW   = 3;

    logic          pclk = 1'b0;
    logic          preset = 1'b1;
    logic          sw_rst_req = 1'b0;
    logic          div_en = 1'b0;
    logic [DW-1:0] div_val = '0;
    logic          timer_rst;
    logic          rst_done;
    logic          cnt_en;
    logic          cfg_pending;

    int checks = 0;
    int errors = 0;

    always #5 pclk = ~pclk;

    timer_clk_rst_ctrl #(
        .RST_HOLD_CYC(HOLD),
        .DIV_W       (DW)
    ) dut (
        .pclk       (pclk),
        .preset     (preset),
        .sw_rst_req (sw_rst_req),
        .div_en     (div_en),
        .div_val    (div_val),
        .timer_rst  (timer_rst),
        .rst_done   (rst_done),
        .cnt_en     (cnt_en),
        .cfg_pending(cfg_pending)
    );

    // Drive inputs for one cycle at the falling edge, then settle before sampling.
    task automatic cyc(input bit p, input bit s, input bit e, input int v);
        @(negedge pclk);
        preset     = p;
        sw_rst_req = s;
        div_en     = e;
        div_val    = DW'(v);
        #1;
    endtask

    // Two preset cycles, four hold cycles and the settle cycle; next cyc is RUN cycle 0.
    task automatic do_reset(input bit e, input int v);
        repeat (2) cyc(1, 0, e, v);
        repeat (HOLD + 1) cyc(0, 0, e, v);
    endtask

    // Reference model: remaining hold cycles, settle flag, run age, tick phase.
    int m_hold, m_run_age, m_val, m_phase;
    bit m_settle, m_en;

    function automatic int m_period();
        return m_en ? (1 << m_val) : 1;
    endfunction

    function automatic bit m_in_run();
        return (m_hold == 0) && !m_settle && (m_run_age >= 0);
    endfunction

    task automatic m_reset();
        m_hold = HOLD; m_settle = 0; m_run_age = -1;
        m_en = 0; m_val = 0; m_phase = 0;
    endtask

    task automatic m_update(input bit p, input bit s, input bit e, input int v);
        if (p) begin
            m_reset();
        end else if (m_hold > 0) begin
            m_en = e; m_val = v; m_phase = 0;
            if (s) m_hold = HOLD;
            else begin
                m_hold--;
                if (m_hold == 0) m_settle = 1;
            end
        end else if (m_settle) begin
            m_en = e; m_val = v; m_settle = 0;
            if (s) m_hold = HOLD;
            else m_run_age = 0;
        end else if (s) begin
            m_hold = HOLD; m_run_age = -1; m_phase = 0;
        end else begin
            m_run_age++;
            if (m_phase == m_period() - 1) begin
                m_phase = 0; m_en = e; m_val = v;
            end else begin
                m_phase++;
            end
        end
    endtask

    task automatic test_reset();
        cyc(1, 0, 0, 0);
        checks++;
        if ({timer_rst, rst_done, cnt_en, cfg_pending} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_outputs got %b want 1000", {timer_rst, rst_done, cnt_en, cfg_pending});
        end
        cyc(1, 0, 0, 0);
        for (int j = 0; j < 10; j++) begin
            cyc(0, 0, 0, 0);
            checks++;
            if (timer_rst !== (j < 4)) begin
                errors++;
                $display("FAIL reset_rst cyc %0d got %b want %b", j, timer_rst, j < 4);
            end
            checks++;
            if (rst_done !== (j == 5)) begin
                errors++;
                $display("FAIL reset_done cyc %0d got %b want %b", j, rst_done, j == 5);
            end
            checks++;
            if (cnt_en !== (j >= 5)) begin
                errors++;
                $display("FAIL reset_cnt cyc %0d got %b want %b", j, cnt_en, j >= 5);
            end
        end
    endtask

    task automatic test_prescale();
        do_reset(1, 3);
        for (int k = 0; k < 32; k++) begin
            cyc(0, 0, 1, 3);
            checks++;
            if (cnt_en !== ((k % 8) == 7)) begin
                errors++;
                $display("FAIL div8_tick run %0d got %b want %b", k, cnt_en, (k % 8) == 7);
            end
            checks++;
            if (cfg_pending !== 1'b0) begin
                errors++;
                $display("FAIL div8_pending run %0d got %b want 0", k, cfg_pending);
            end
        end
    endtask

    task automatic test_cfg_change();
        bit et, ep;
        do_reset(1, 3);
        for (int k = 0; k < 16; k++) begin
            cyc(0, 0, 1, (k >= 3) ? 1 : 3);
            et = (k == 7) || (k >= 9 && (k % 2) == 1);
            ep = (k >= 3) && (k <= 7);
            checks++;
            if (cnt_en !== et) begin
                errors++;
                $display("FAIL cfg_tick run %0d got %b want %b", k, cnt_en, et);
            end
            checks++;
            if (cfg_pending !== ep) begin
                errors++;
                $display("FAIL cfg_pending run %0d got %b want %b", k, cfg_pending, ep);
            end
        end
    endtask

    task automatic test_sw_reset_run();
        bit er, ed, ec;
        do_reset(0, 0);
        for (int k = 0; k < 18; k++) begin
            cyc(0, k == 10, 0, 0);
            er = (k >= 11) && (k <= 14);
            ed = (k == 0) || (k == 16);
            ec = (k < 10) || (k >= 16);
            checks++;
            if ({timer_rst, rst_done, cnt_en} !== {er, ed, ec}) begin
                errors++;
                $display("FAIL swrun cyc %0d got rst/done/cnt %b want %b", k,
                         {timer_rst, rst_done, cnt_en}, {er, ed, ec});
            end
        end
    endtask

    task automatic test_sw_reset_hold();
        repeat (2) cyc(1, 0, 0, 0);
        for (int j = 0; j < 10; j++) begin
            cyc(0, j == 2, 0, 0);
            checks++;
            if (timer_rst !== (j < 7)) begin
                errors++;
                $display("FAIL swhold_rst cyc %0d got %b want %b", j, timer_rst, j < 7);
            end
            checks++;
            if (rst_done !== (j == 8)) begin
                errors++;
                $display("FAIL swhold_done cyc %0d got %b want %b", j, rst_done, j == 8);
            end
        end
    endtask

    task automatic test_preset_on_tick();
        bit er, ed, ec;
        do_reset(1, 1);
        for (int k = 0; k < 5; k++) begin
            cyc(0, 0, 1, 1);
            checks++;
            if (cnt_en !== ((k % 2) == 1)) begin
                errors++;
                $display("FAIL ptick_pre run %0d got %b want %b", k, cnt_en, (k % 2) == 1);
            end
        end
        cyc(1, 0, 1, 1);
        checks++;
        if (cnt_en !== 1'b0) begin
            errors++;
            $display("FAIL ptick_masked got %b want 0", cnt_en);
        end
        for (int j = 0; j < 8; j++) begin
            cyc(0, 0, 1, 1);
            er = (j < 4);
            ed = (j == 5);
            ec = (j == 6);
            checks++;
            if ({timer_rst, rst_done, cnt_en} !== {er, ed, ec}) begin
                errors++;
                $display("FAIL ptick_seq cyc %0d got rst/done/cnt %b want %b", j,
                         {timer_rst, rst_done, cnt_en}, {er, ed, ec});
            end
        end
    endtask

    task automatic test_random();
        bit p, s, e, ec, ep;
        int v;
        e = 1; v = 2;
        cyc(1, 0, e, v);
        m_reset();
        for (int i = 0; i < 3000; i++) begin
            p = ($urandom_range(0, 299) == 0);
            s = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 39) == 0) begin
                e = 1'($urandom_range(0, 1));
                v = ($urandom_range(0, 9) == 0) ? 7 : int'($urandom_range(0, 4));
            end
            cyc(p, s, e, v);
            ec = m_in_run() && (m_phase == m_period() - 1) && !p && !s;
            ep = m_in_run() && ((e != m_en) || (v != m_val));
            checks++;
            if (timer_rst !== (m_hold > 0)) begin
                errors++;
                $display("FAIL rnd_rst i %0d got %b want %b", i, timer_rst, m_hold > 0);
            end
            checks++;
            if (rst_done !== (m_run_age == 0)) begin
                errors++;
                $display("FAIL rnd_done i %0d got %b want %b", i, rst_done, m_run_age == 0);
            end
            checks++;
            if (cnt_en !== ec) begin
                errors++;
                $display("FAIL rnd_cnt i %0d got %b want %b", i, cnt_en, ec);
            end
            checks++;
            if (cfg_pending !== ep) begin
                errors++;
                $display("FAIL rnd_pending i %0d got %b want %b", i, cfg_pending, ep);
            end
            m_update(p, s, e, v);
        end
    endtask

    initial begin
        test_reset();
        test_prescale();
        test_cfg_change();
        test_sw_reset_run();
        test_sw_reset_hold();
        test_preset_on_tick();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
